// File: rtl/fixed_pkg.sv
// Shared constants and state types for the fixed-point arithmetic library.
// The multiplier and divider use the same default operand format.
package fixed_pkg;
    localparam int DEF_INPUT_WIDTH = 32;
    localparam int DEF_INPUT_POINT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/mod_fixed_div_step.sv
// One restoring shift-subtract iteration: bring in the next numerator bit,
// subtract the divisor when it fits, and emit the quotient bit.
module mod_fixed_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem,
    input  logic         nbit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_next,
    output logic         qbit
);
    logic [W:0] shifted;

    // A set rem[W] means the shifted value is at least 2^(W+1) and so always
    // exceeds the divisor; the W+1-bit difference is still exact.
    assign shifted  = {rem[W-1:0], nbit};
    assign qbit     = rem[W] | (shifted >= {1'b0, divisor});
    assign rem_next = qbit ? (shifted - {1'b0, divisor}) : shifted;
endmodule

// File: rtl/mod_fixed_div.sv
// Sequential unsigned fixed-point divider: (a << POINT) / b, one quotient bit
// per clock, saturating to all ones on divide-by-zero or overflow.
module mod_fixed_div
    import fixed_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int INPUT_POINT = DEF_INPUT_POINT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [INPUT_WIDTH-1:0] i_a,
    input  logic [INPUT_WIDTH-1:0] i_b,
    input  logic                   i_trigger,
    output logic [INPUT_WIDTH-1:0] o_out,
    output logic                   o_ready,
    output logic                   o_div_zero,
    output logic                   o_overflow
);
    localparam int Q  = INPUT_WIDTH + INPUT_POINT;
    localparam int CW = $clog2(Q + 1);

    div_state_t             state, state_next;
    logic [Q-1:0]           num;
    logic [Q-1:0]           quo;
    logic [INPUT_WIDTH-1:0] divisor;
    logic [INPUT_WIDTH:0]   rem, rem_next;
    logic [CW-1:0]          cnt;
    logic                   qbit;
    logic                   accept;

    assign accept = (state == IDLE) && o_ready && i_trigger;

    mod_fixed_div_step #(.W(INPUT_WIDTH)) u_step (
        .rem      (rem),
        .nbit     (num[Q-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (i_b == '0) ? DONE : RUN;
            RUN:  if (cnt == CW'(1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // o_ready stays low for the first IDLE cycle after DONE, so results are
    // spaced Q+3 cycles apart when the trigger is held high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num        <= '0;
            quo        <= '0;
            divisor    <= '0;
            rem        <= '0;
            cnt        <= '0;
            o_out      <= '0;
            o_ready    <= 1'b1;
            o_div_zero <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        num     <= {i_a, {INPUT_POINT{1'b0}}};
                        divisor <= i_b;
                        rem     <= '0;
                        quo     <= '0;
                        cnt     <= CW'(Q);
                        o_ready <= 1'b0;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                RUN: begin
                    num <= num << 1;
                    rem <= rem_next;
                    quo <= {quo[Q-2:0], qbit};
                    cnt <= cnt - CW'(1);
                end
                DONE: begin
                    if (divisor == '0) begin
                        o_out      <= '1;
                        o_div_zero <= 1'b1;
                        o_overflow <= 1'b0;
                    end else if (|quo[Q-1:INPUT_WIDTH]) begin
                        o_out      <= '1;
                        o_div_zero <= 1'b0;
                        o_overflow <= 1'b1;
                    end else begin
                        o_out      <= quo[INPUT_WIDTH-1:0];
                        o_div_zero <= 1'b0;
                        o_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_fixed_div.sv
// Randomized and directed checks of mod_fixed_div against an arithmetic model.
module tb_mod_fixed_div;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        trig = 1'b0;
    logic [31:0] out;
    logic        ready, dz, ov;

    int n_cmp = 0;
    int n_bad = 0;

    mod_fixed_div dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_trigger(trig),
        .o_out(out), .o_ready(ready), .o_div_zero(dz), .o_overflow(ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: real-number quotient of a/2^8 by b/2^8, truncated, in 2^-8 units.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb);
        longint unsigned num, q;
        if (mb == 0) return {1'b1, 1'b0, 32'hFFFF_FFFF};
        num = longint'(ma) * 256;
        q = num / longint'(mb);
        if (q > 64'hFFFF_FFFF) return {1'b0, 1'b1, 32'hFFFF_FFFF};
        return {2'b00, q[31:0]};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin @(negedge clk); n++; end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                         output int lat);
        logic [33:0] e;
        @(negedge clk);
        wait_ready();
        a = oa; b = ob; trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        while (!ready && lat < 200) begin lat++; @(negedge clk); end
        e = model(oa, ob);
        chk({tag, "_out"}, out, e[31:0]);
        chk({tag, "_dz"}, dz, e[33]);
        chk({tag, "_ov"}, ov, e[32]);
    endtask

    initial begin
        int lat, cyc;
        logic [31:0] ra, rb;
        logic [33:0] e;
        logic [31:0] ha [3];
        logic [31:0] hb [3];

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_out", out, 0);
        chk("rst_dz", dz, 0);
        chk("rst_ov", ov, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("one", 32'h100, 32'h100, lat);
        chk("one_lat", lat, 42);
        do_op("r1p5", 32'h300, 32'h200, lat);
        do_op("trunc", 32'h100, 32'h300, lat);
        chk("trunc_val", out, 32'h55);
        do_op("dzero", 32'h1234, 32'h0, lat);
        chk("dzero_lat", lat, 2);
        do_op("after_dz", 32'h200, 32'h100, lat);
        do_op("ovf", 32'hFFFF_FFFF, 32'h1, lat);
        do_op("no_ovf", 32'h00FF_FFFF, 32'h100, lat);
        chk("no_ovf_val", out, 32'h00FF_FFFF);

        // Triggers during a busy period must be dropped, not queued.
        @(negedge clk);
        wait_ready();
        a = 32'h300; b = 32'h200; trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        cyc = 1;
        while (cyc < 60 && !ready) begin
            if (cyc == 5 || cyc == 20) begin a = 32'h1; b = 32'h7; trig = 1'b1; end
            else trig = 1'b0;
            @(negedge clk);
            cyc++;
        end
        trig = 1'b0;
        chk("ign_out", out, 32'h180);
        repeat (3) @(negedge clk);
        chk("ign_noqueue", ready, 1);
        chk("ign_hold", out, 32'h180);

        // Trigger held high: one result every 43 cycles.
        ha[0] = 32'h400; hb[0] = 32'h200;
        ha[1] = 32'h900; hb[1] = 32'h300;
        ha[2] = 32'h100; hb[2] = 32'h800;
        a = ha[0]; b = hb[0]; trig = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cyc = 1;
            while (!ready && cyc < 200) begin @(negedge clk); cyc++; end
            chk($sformatf("held_gap%0d", k), cyc, 43);
            e = model(ha[k], hb[k]);
            chk($sformatf("held_out%0d", k), out, e[31:0]);
            if (k < 2) begin a = ha[k+1]; b = hb[k+1]; end
        end
        trig = 1'b0;

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        wait_ready();
        a = 32'h700; b = 32'h300; trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_flags", {dz, ov}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 32'h500, 32'h100, lat);
        chk("post_rst_lat", lat, 42);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 16);
                2: rb = $urandom >> $urandom_range(8, 31);
                default: rb = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), ra, rb, lat);
            chk($sformatf("rnd%0d_lat", i), lat, (rb == 0) ? 2 : 42);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
